// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// default latencies and the 64-bit {hi,lo} result type.
package mdu_pkg;

   typedef enum logic [3:0] {
      MD_NOP   = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MFHI  = 4'd5,
      MD_MFLO  = 4'd6,
      MD_MTHI  = 4'd7,
      MD_MTLO  = 4'd8
   } md_op_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   typedef logic [63:0] md_result_t;

   function automatic logic is_muldiv(input logic [3:0] op);
      return (op >= 4'(MD_MULT)) && (op <= 4'(MD_DIVU));
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath producing {hi,lo} and a divide-by-zero flag.
module mdu_calc
   import mdu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output md_result_t  result,
   output logic        div_by_zero
);

   logic [31:0] a_mag, b_mag, b_sdiv, b_udiv;
   logic [31:0] q_s, r_s;

   // Signed divide done on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
   assign a_mag  = a[31] ? (~a + 32'd1) : a;
   assign b_mag  = b[31] ? (~b + 32'd1) : b;
   assign b_sdiv = (b_mag == 32'd0) ? 32'd1 : b_mag;
   assign b_udiv = (b == 32'd0) ? 32'd1 : b;
   assign q_s    = a_mag / b_sdiv;
   assign r_s    = a_mag % b_sdiv;

   always_comb begin
      result      = '0;
      div_by_zero = 1'b0;
      case (md_op_e'(op))
         MD_MULT:  result = {{32{a[31]}}, a} * {{32{b[31]}}, b};
         MD_MULTU: result = {32'd0, a} * {32'd0, b};
         MD_DIV: begin
            div_by_zero = (b == 32'd0);
            result[31:0]  = (a[31] ^ b[31]) ? (~q_s + 32'd1) : q_s;
            result[63:32] = a[31] ? (~r_s + 32'd1) : r_s;
         end
         MD_DIVU: begin
            div_by_zero = (b == 32'd0);
            result      = {a % b_udiv, a / b_udiv};
         end
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/e_mdu.sv
// E-stage MD unit: owns HI/LO and emulates multi-cycle latency with a busy down-counter.
// Optional MDU_CANCEL_EN adds a cancel input that suppresses start and MTHI/MTLO.
module e_mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        md_en,
   input  logic [3:0]  md_op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
`ifdef MDU_CANCEL_EN
   input  logic        cancel,
`endif
   output logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_out
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   logic [CW-1:0] count;
   logic [31:0]   pend_hi, pend_lo;
   logic          pend_dz;
   logic          issue, is_md, is_mt, mt_wr, calc_dz;
   logic [CW-1:0] load_val;
   md_result_t    calc_res;

`ifdef MDU_CANCEL_EN
   assign issue = md_en & ~cancel;
`else
   assign issue = md_en;
`endif

   assign is_md    = is_muldiv(md_op);
   assign is_mt    = (md_op == 4'(MD_MTHI)) || (md_op == 4'(MD_MTLO));
   assign start    = issue & is_md & ~busy;
   assign mt_wr    = issue & is_mt & ~busy;
   assign load_val = (md_op == 4'(MD_MULT) || md_op == 4'(MD_MULTU)) ?
                     CW'(MULT_CYCLES) : CW'(DIV_CYCLES);

   always_comb begin
      md_out = '0;
      if (md_op == 4'(MD_MFHI))      md_out = hi;
      else if (md_op == 4'(MD_MFLO)) md_out = lo;
   end

   mdu_calc u_calc (
      .op          (md_op),
      .a           (rs_data),
      .b           (rt_data),
      .result      (calc_res),
      .div_by_zero (calc_dz)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         busy    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_dz <= 1'b0;
      end else begin
         if (start) begin
            count   <= load_val;
            busy    <= 1'b1;
            pend_hi <= calc_res[63:32];
            pend_lo <= calc_res[31:0];
            pend_dz <= calc_dz;
         end else if (count == CW'(1)) begin
            count <= '0;
            busy  <= 1'b0;
            if (!pend_dz) begin
               hi <= pend_hi;
               lo <= pend_lo;
            end
         end else if (count != '0) begin
            count <= count - CW'(1);
         end
         // MTHI/MTLO only lands when idle, so it never collides with a commit.
         if (mt_wr && md_op == 4'(MD_MTHI)) hi <= rs_data;
         if (mt_wr && md_op == 4'(MD_MTLO)) lo <= rs_data;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!reset && issue)
         assert (!(busy && (is_md || is_mt)) && (md_op <= 4'(MD_MTLO)))
         else $warning("e_mdu: illegal md_op %0d issued (busy=%0b), ignored", md_op, busy);
   end
`endif

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed cases plus randomized ops against a
// schedule-based reference model using plain 64-bit arithmetic.
module tb_e_mdu;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset, md_en;
   logic [3:0]  md_op;
   logic [31:0] rs_data, rt_data;
   logic        start, busy;
   logic [31:0] hi, lo, md_out;
`ifdef MDU_CANCEL_EN
   logic        cancel = 1'b0;
`endif

   always #5 clk = ~clk;

   e_mdu dut (
      .clk     (clk),
      .reset   (reset),
      .md_en   (md_en),
      .md_op   (md_op),
      .rs_data (rs_data),
      .rt_data (rt_data),
`ifdef MDU_CANCEL_EN
      .cancel  (cancel),
`endif
      .start   (start),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo),
      .md_out  (md_out)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // reference state: architectural HI/LO plus one scheduled pending result
   int          cyc = 0;
   logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
   bit          p_valid = 0, p_dz = 0;
   int          done_cyc = 0;

   task automatic compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rh, output logic [31:0] rl, output bit dz);
      longint      sp, sq, sr;
      logic [63:0] up;
      rh = 0; rl = 0; dz = 0;
      case (op)
         4'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); rh = sp[63:32]; rl = sp[31:0]; end
         4'd2: begin up = {32'd0, a} * {32'd0, b}; rh = up[63:32]; rl = up[31:0]; end
         4'd3: if (b == 0) dz = 1;
               else begin
                  sq = longint'($signed(a)) / longint'($signed(b));
                  sr = longint'($signed(a)) % longint'($signed(b));
                  rl = sq[31:0]; rh = sr[31:0];
               end
         4'd4: if (b == 0) dz = 1; else begin rl = a / b; rh = a % b; end
         default: ;
      endcase
   endtask

   task automatic step(input bit en, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit rst = 0, input bit cn = 0);
      bit          m_busy, m_start, m_legal;
      logic [31:0] exp_out;
      if (p_valid && cyc == done_cyc) begin
         if (!p_dz) begin m_hi = p_hi; m_lo = p_lo; end
         p_valid = 0;
      end
      m_busy = p_valid;
      md_en = en; md_op = op; rs_data = a; rt_data = b; reset = rst;
`ifdef MDU_CANCEL_EN
      cancel = cn;
`endif
      #1;
      m_legal = en && !cn && !m_busy;
      m_start = m_legal && (op >= 4'd1) && (op <= 4'd4);
      exp_out = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
      check_eq("busy",   {31'd0, busy},  {31'd0, m_busy});
      check_eq("start",  {31'd0, start}, {31'd0, m_start});
      check_eq("hi",     hi,     m_hi);
      check_eq("lo",     lo,     m_lo);
      check_eq("md_out", md_out, exp_out);
      if (m_start) begin
         compute(op, a, b, p_hi, p_lo, p_dz);
         p_valid  = 1;
         done_cyc = cyc + ((op <= 4'd2) ? 5 : 10) + 1;
      end else if (m_legal && op == 4'd7) m_hi = a;
      else if (m_legal && op == 4'd8) m_lo = a;
      if (rst) begin m_hi = 0; m_lo = 0; p_valid = 0; end
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 4'd0, 32'd0, 32'd0);
   endtask

   initial begin
      reset = 1; md_en = 0; md_op = 0; rs_data = 0; rt_data = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      idle(1);

      step(1, MD_MULT, 32'hFFFFFFFF, 32'd2);
      idle(5);
      check_eq("mult_hi", hi, 32'hFFFFFFFF);
      check_eq("mult_lo", lo, 32'hFFFFFFFE);
      check_eq("mult_busy_end", {31'd0, busy}, 32'd0);

      step(1, MD_MULTU, 32'hFFFFFFFF, 32'd2);
      idle(5);
      check_eq("multu_hi", hi, 32'h00000001);
      check_eq("multu_lo", lo, 32'hFFFFFFFE);

      step(1, MD_DIV, 32'hFFFFFFF9, 32'd2);
      idle(10);
      check_eq("div_lo", lo, 32'hFFFFFFFD);
      check_eq("div_hi", hi, 32'hFFFFFFFF);

      step(1, MD_DIVU, 32'd7, 32'd2);
      idle(10);
      check_eq("divu_lo", lo, 32'd3);
      check_eq("divu_hi", hi, 32'd1);

      step(1, MD_MTHI, 32'hAAAA0000, 32'd0);
      step(1, MD_MTLO, 32'h00005555, 32'd0);
      step(1, MD_DIV, 32'd1234, 32'd0);
      idle(10);
      check_eq("dz_hi", hi, 32'hAAAA0000);
      check_eq("dz_lo", lo, 32'h00005555);

      step(1, MD_DIV, 32'h80000000, 32'hFFFFFFFF);
      idle(10);
      check_eq("ovf_lo", lo, 32'h80000000);
      check_eq("ovf_hi", hi, 32'h00000000);

      step(1, MD_MTHI, 32'h12345678, 32'd0);
      step(1, MD_MFHI, 32'd0, 32'd0);
      check_eq("mfhi_hi", hi, 32'h12345678);

      step(1, MD_MULT, 32'd6, 32'd7);
      step(1, MD_MTLO, 32'hDEADBEEF, 32'd0);
      idle(4);
      check_eq("mtlo_busy_lo", lo, 32'd42);

      step(1, MD_DIV, 32'd100, 32'd3);
      idle(2);
      step(0, 4'd0, 32'd0, 32'd0, 1);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_hi", hi, 32'd0);
      check_eq("rst_lo", lo, 32'd0);
      idle(12);
      check_eq("rst_nolate_lo", lo, 32'd0);

`ifdef MDU_CANCEL_EN
      step(1, MD_MULT, 32'd3, 32'd4, 0, 1);
      idle(6);
      check_eq("cancel_lo", lo, 32'd0);
      step(1, MD_MTHI, 32'h0BADF00D, 32'd0, 0, 1);
      idle(1);
      check_eq("cancel_mthi", hi, 32'd0);
      step(1, MD_DIVU, 32'd9, 32'd2);
      step(1, MD_MULT, 32'd1, 32'd1, 0, 1);
      idle(9);
      check_eq("cancel_inflight_lo", lo, 32'd4);
`endif

      for (int i = 0; i < 400; i++) begin
         logic [31:0] a, b;
         logic [3:0]  op;
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'hFFFFFFFF;
            2: a = 32'h80000000;
            3: b = $urandom_range(0, 9);
            default: ;
         endcase
         if (p_valid) begin
            op = 4'($urandom_range(5, 6));
            step($urandom_range(0, 1) == 1, op, a, b);
         end else begin
            op = 4'($urandom_range(0, 8));
            step($urandom_range(0, 3) != 0, op, a, b);
         end
      end
      idle(12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- E-stage multiply/divide unit of the 5-stage MIPS pipeline; executes mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- Owns the HI/LO architectural registers.
- Its md_out result is carried into the E/M pipeline register as the MD result.
- Emulates multi-cycle latency via a busy counter; the hazard unit stalls D-stage MD instructions while start or busy is high.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu.
- DIV_CYCLES, 10, busy duration in cycles for div/divu.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- md_en  input  1  a valid MD instruction is in E this cycle.
- md_op  input  4  operation code; encodings in mdu_pkg.
- rs_data  input  32  forwarded GPR[rs]: dividend or multiplicand.
- rt_data  input  32  forwarded GPR[rt]: divisor or multiplier.
- start  output  1  combinational; md_en & op in {MULT, MULTU, DIV, DIVU} & !busy.
- busy  output  1  registered; high while an operation is in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.
- md_out  output  32  combinational; hi when md_op==MFHI, lo when md_op==MFLO, else 0.

Behaviour:
- Reset (synchronous, active-high): hi=0, lo=0, counter=0, busy=0, pending result regs=0. Reset mid-operation aborts the operation and discards its result.
- Start at cycle t, i.e. start=1 sampled at posedge ending t:
  - Operands captured; result computed into pending_hi/pending_lo.
  - Counter loaded with MULT_CYCLES or DIV_CYCLES.
  - busy=1 during cycles t+1 .. t+N.
- Commit: at the posedge where counter==1, hi<=pending_hi, lo<=pending_lo, counter<=0.
  - New values are visible at cycle t+N+1, the same cycle busy falls.
  - busy = (counter != 0), registered.
- MULT: signed 32x32 to 64-bit; {hi,lo} = product. MULTU: unsigned.
- DIV: signed; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (rt_data==0, DIV or DIVU): busy sequence runs normally; hi/lo retain their previous values at commit.
- MTHI/MTLO: with md_en & !busy, hi or lo <= rs_data at the posedge. Visible via md_out in the next cycle.
- MFHI/MFLO: read current hi/lo combinationally; no state change.
- Illegal cases, all ignored with no state change:
  - md_en with a mult/div op while busy.
  - MTHI/MTLO while busy.
  - md_op values outside the defined set.
  - A simulation-only assertion flags each of these; the hazard unit must prevent them.
- Back-to-back: a new start is accepted in cycle t+N+1. The commit and the new capture occur on different edges.

Optional Feature:
- Macro: MDU_CANCEL_EN.
- Defined:
  - Adds input port cancel (1 bit), asserted when an exception or interrupt flushes the E-stage instruction.
  - cancel=1 suppresses start and MTHI/MTLO writes in that cycle.
  - An in-flight operation (busy=1) is not affected and still commits.
- Undefined: no cancel port; behaviour as above.

Decomposition:
- Package mdu_pkg:
  - md_op encodings: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
  - Default cycle constants.
  - 64-bit result type.
- Sub-module mdu_calc (combinational): takes op and operands, returns {hi,lo} plus a div_by_zero flag.
- e_mdu holds the counter, pending registers, HI/LO and control.

Test Plan:
- MULT, rs=0xFFFFFFFF, rt=2, start at t -> busy=1 for t+1..t+5; at t+6 hi=0xFFFFFFFF, lo=0xFFFFFFFE, busy=0.
- MULTU, same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- DIV, rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
- DIV with rt=0, prior hi=0xAAAA0000, lo=0x5555 -> busy 10 cycles; hi/lo unchanged.
- MTHI rs=0x12345678, then MFHI next cycle -> md_out=0x12345678. MTLO issued during busy -> lo unchanged and assertion fires.
- Reset asserted during the 3rd busy cycle of a DIV -> next cycle busy=0, hi=lo=0, no late commit. With MDU_CANCEL_EN, start with cancel=1 -> busy stays 0 and hi/lo unchanged.
